// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: dispatch line layout and FU port numbering.
package reservation_station_pkg;

  localparam int PREG_W_PKG = 6;

  localparam int FU_ALU0 = 0;
  localparam int FU_ALU1 = 1;
  localparam int FU_MEM  = 2;
  localparam int NUM_FU  = 3;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            fu;
    logic [3:0]            op;
    logic [PREG_W_PKG-1:0] rd;
    logic [PREG_W_PKG-1:0] rs1;
    logic [PREG_W_PKG-1:0] rs2;
    logic                  src1rdy;
    logic                  src2rdy;
    logic                  alu_src;
    logic [15:0]           imm;
  } rsEntry;

  typedef struct packed {
    rsEntry line_a;
    rsEntry line_b;
  } dispatchStruct;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder: reports whether any bit is set and the index of the lowest one.
module rs_select #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Unified reservation station: holds dispatched lines until operands are ready, issues to ALU0/ALU1/MEM.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_DEPTH = 16,
  parameter int PREG_W   = PREG_W_PKG,
  parameter int NUM_WAKE = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  rsEntry                          rs_in_a,
  input  rsEntry                          rs_in_b,
  output logic                            rs_stall,
  input  logic [NUM_WAKE-1:0]             wake_valid,
  input  logic [NUM_WAKE-1:0][PREG_W-1:0] wake_tag,
  output logic [NUM_FU-1:0]               issue_valid,
  output rsEntry [NUM_FU-1:0]             issue_entry,
  input  logic [NUM_FU-1:0]               issue_ready,
  output logic [$clog2(RS_DEPTH):0]       rs_count
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  function automatic logic tag_hit(input logic [PREG_W-1:0]             tag,
                                   input logic [NUM_WAKE-1:0]             wv,
                                   input logic [NUM_WAKE-1:0][PREG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < NUM_WAKE; w++) hit = hit | (wv[w] && (wt[w] == tag));
    return hit;
  endfunction

  // A line captured this cycle also picks up any same-cycle broadcast.
  function automatic rsEntry capture(input rsEntry                          e,
                                     input logic [NUM_WAKE-1:0]             wv,
                                     input logic [NUM_WAKE-1:0][PREG_W-1:0] wt);
    rsEntry r;
    r         = e;
    r.src1rdy = e.src1rdy | tag_hit(e.rs1, wv, wt);
    r.src2rdy = e.src2rdy | e.alu_src | tag_hit(e.rs2, wv, wt);
    return r;
  endfunction

  logic [RS_DEPTH-1:0] ent_vld;
  logic [RS_DEPTH-1:0] ent_vld_nxt;
  rsEntry              ent [RS_DEPTH];

  logic                free_a, free_b;
  logic [IDX_W-1:0]    slot_a, slot_b, slot_wb;
  logic                wr_a, wr_b;
  rsEntry              line_a, line_b;

  logic [RS_DEPTH-1:0] elig [NUM_FU];
  logic [NUM_FU-1:0]   sel_found;
  logic [IDX_W-1:0]    sel_idx [NUM_FU];
  rsEntry              sel_ent [NUM_FU];
  logic [NUM_FU-1:0]   take;
  logic [RS_DEPTH-1:0] clr;
  logic [1:0]          n_wr, n_iss;

  assign rs_stall = (rs_count > CNT_W'(RS_DEPTH - 2));

  always_comb begin
    free_a = 1'b0;
    free_b = 1'b0;
    slot_a = '0;
    slot_b = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!ent_vld[i]) begin
        if (!free_a) begin
          free_a = 1'b1;
          slot_a = IDX_W'(i);
        end else if (!free_b) begin
          free_b = 1'b1;
          slot_b = IDX_W'(i);
        end
      end
    end
  end

  assign wr_a    = rs_in_a.valid && !rs_stall && free_a;
  assign slot_wb = rs_in_a.valid ? slot_b : slot_a;
  assign wr_b    = rs_in_b.valid && !rs_stall && (rs_in_a.valid ? free_b : free_a);
  assign line_a  = capture(rs_in_a, wake_valid, wake_tag);
  assign line_b  = capture(rs_in_b, wake_valid, wake_tag);

  always_comb begin
    for (int p = 0; p < NUM_FU; p++) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        elig[p][i] = ent_vld[i] && ent[i].src1rdy && ent[i].src2rdy && (ent[i].fu == 2'(p));
      end
    end
  end

  for (genvar p = 0; p < NUM_FU; p++) begin : g_port
    rs_select #(.N(RS_DEPTH), .IDX_W(IDX_W)) u_sel (
      .eligible (elig[p]),
      .found    (sel_found[p]),
      .index    (sel_idx[p])
    );
  end

  // A port only selects when its issue register is empty or being drained this edge.
  always_comb begin
    clr = '0;
    for (int p = 0; p < NUM_FU; p++) begin
      take[p]          = (!issue_valid[p] || issue_ready[p]) && sel_found[p];
      sel_ent[p]       = ent[sel_idx[p]];
      sel_ent[p].valid = 1'b1;
      if (take[p]) clr[sel_idx[p]] = 1'b1;
    end
  end

  always_comb begin
    ent_vld_nxt = ent_vld & ~clr;
    if (wr_a) ent_vld_nxt[slot_a]  = 1'b1;
    if (wr_b) ent_vld_nxt[slot_wb] = 1'b1;
  end

  assign n_wr  = 2'(wr_a) + 2'(wr_b);
  assign n_iss = popcount3(take);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_vld  <= '0;
      rs_count <= '0;
    end else if (flush) begin
      ent_vld  <= '0;
      rs_count <= '0;
    end else begin
      ent_vld  <= ent_vld_nxt;
      rs_count <= rs_count + CNT_W'(n_wr) - CNT_W'(n_iss);
    end
  end

  // Entry payload carries no reset: a slot's contents matter only while its valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (wr_a && (slot_a == IDX_W'(i))) begin
        ent[i] <= line_a;
      end else if (wr_b && (slot_wb == IDX_W'(i))) begin
        ent[i] <= line_b;
      end else if (ent_vld[i]) begin
        if (tag_hit(ent[i].rs1, wake_valid, wake_tag)) ent[i].src1rdy <= 1'b1;
        if (tag_hit(ent[i].rs2, wake_valid, wake_tag)) ent[i].src2rdy <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid <= '0;
      issue_entry <= '0;
    end else if (flush) begin
      issue_valid <= '0;
      issue_entry <= '0;
    end else begin
      for (int p = 0; p < NUM_FU; p++) begin
        if (!issue_valid[p] || issue_ready[p]) begin
          issue_valid[p] <= sel_found[p];
          if (sel_found[p]) issue_entry[p] <= sel_ent[p];
        end
      end
    end
  end

  a_no_write_on_stall: assert property (@(posedge clk) disable iff (reset)
    rs_stall |-> !(rs_in_a.valid || rs_in_b.valid));

  a_count_in_range: assert property (@(posedge clk) disable iff (reset)
    rs_count <= CNT_W'(RS_DEPTH));

  a_no_fu3_a: assert property (@(posedge clk) disable iff (reset)
    rs_in_a.valid |-> (rs_in_a.fu != 2'd3));

  a_no_fu3_b: assert property (@(posedge clk) disable iff (reset)
    rs_in_b.valid |-> (rs_in_b.fu != 2'd3));

endmodule
